// File: rtl/nco_mc_pkg.sv
// nco_mc_pkg: shared constants, quadrant type and table helpers for nco_mc.
// LFSR geometry (dither build NCO_MC_DITHER_EN), quarter-sine entry generator.
package nco_mc_pkg;

  localparam int LFSR_W = 24;
  // taps 24,23,22,17 -> bits 23,22,21,16
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE1_0000;

  typedef enum logic [1:0] {
    QUAD_0,
    QUAD_1,
    QUAD_2,
    QUAD_3
  } quad_t;

  // Quarter-wave entry k, sampled at bin centres so no entry is zero.
  function automatic int quarter_sin(int k, int aw, int ow);
    real amp;
    real x;
    amp = real'((1 << (ow - 1)) - 1);
    x = 3.14159265358979 / 2.0 * (real'(k) + 0.5)
        / real'(1 << (aw - 2));
    return int'(amp * $sin(x));
  endfunction

  // XNOR feedback keeps all-zeros a legal (reset) state.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    logic [LFSR_W-1:0] s
  );
    logic fb;
    fb = ~(^(s & LFSR_TAPS));
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/nco_mc_if.sv
// nco_mc_if: AXI-stream style bundle (tdata/tuser/tlast/tvalid/tready).
// master drives data+valid, slave drives ready.
interface nco_mc_if #(
  parameter int DW = 32,
  parameter int UW = 2
);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: quarter-sine table with mirror/negate, registered on en.
// Ports: aclk, arst_n, en, addr (full-cycle phase), data (signed sample).
module nco_quarter_lut
  import nco_mc_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic                    en,
  input  logic [LUT_AW-1:0]       addr,
  output logic signed [OUT_W-1:0] data
);

  localparam int QN = 1 << (LUT_AW - 2);

  logic signed [OUT_W-1:0] rom [QN];

  for (genvar k = 0; k < QN; k++) begin : g_rom
    assign rom[k] = OUT_W'(quarter_sin(k, LUT_AW, OUT_W));
  end

  quad_t                   q;
  logic [LUT_AW-3:0]       idx;
  logic                    neg;
  logic signed [OUT_W-1:0] mag;

  assign q = quad_t'(addr[LUT_AW-1 -: 2]);

  always_comb begin
    idx = addr[LUT_AW-3:0];
    neg = 1'b0;
    unique case (q)
      QUAD_0: neg = 1'b0;
      QUAD_1: idx = ~addr[LUT_AW-3:0];
      QUAD_2: neg = 1'b1;
      QUAD_3: begin
        idx = ~addr[LUT_AW-3:0];
        neg = 1'b1;
      end
    endcase
  end

  assign mag = rom[idx];

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      data <= '0;
    end else if (en) begin
      data <= neg ? -mag : mag;
    end
  end

endmodule

// File: rtl/nco_mc.sv
// nco_mc: round-robin multichannel NCO, 2-stage pipeline, optional dither
// (NCO_MC_DITHER_EN). Ports: aclk, arst_n, s_axis_cfg (fword write,
// tuser=channel), phase_offset, sync_clr, dither_en, m_axis (samples).
module nco_mc
  import nco_mc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  nco_mc_if.slave                   s_axis_cfg,
  input  logic [NUM_CH*PHASE_W-1:0] phase_offset,
  input  logic                      sync_clr,
  input  logic                      dither_en,
  nco_mc_if.master                  m_axis
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NCH  = (CH_W + 1)'(NUM_CH);

  logic                    en;
  logic                    cfg_rdy;
  logic                    cfg_we;
  logic [CH_W-1:0]         ch_ptr;
  logic [PHASE_W-1:0]      acc     [NUM_CH];
  logic [PHASE_W-1:0]      fword   [NUM_CH];
  logic [PHASE_W-1:0]      off_arr [NUM_CH];
  logic [PHASE_W-1:0]      dith;
  logic [PHASE_W-1:0]      ph_sum;
  logic                    s1_valid;
  logic [CH_W-1:0]         s1_ch;
  logic [LUT_AW-1:0]       s1_addr;
  logic signed [OUT_W-1:0] lut_q;
  logic                    unused_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_off
    assign off_arr[c] = phase_offset[c*PHASE_W +: PHASE_W];
  end

  assign en     = ~m_axis.tvalid | m_axis.tready;
  assign cfg_we = s_axis_cfg.tvalid & cfg_rdy
                & ({1'b0, s_axis_cfg.tuser} < NCH);
  assign s_axis_cfg.tready = cfg_rdy;

`ifdef NCO_MC_DITHER_EN
  localparam int DIT_W = PHASE_W - LUT_AW;

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr <= '0;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign dith = dither_en ? PHASE_W'(lfsr[DIT_W-1:0]) : '0;
`else
  logic unused_dither;
  assign unused_dither = dither_en;
  assign dith = '0;
`endif

  assign ph_sum = acc[ch_ptr] + off_arr[ch_ptr] + dith;

  // Only the top LUT_AW phase bits address the table.
  assign unused_ok = ^{s_axis_cfg.tlast,
                       ph_sum[PHASE_W-LUT_AW-1:0]};

  // Issue reads fword before a same-edge cfg write lands.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]   <= '0;
        fword[c] <= '0;
      end
    end else begin
      if (cfg_we) begin
        fword[s_axis_cfg.tuser] <= s_axis_cfg.tdata;
      end
      if (sync_clr) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc[c] <= '0;
        end
      end else if (en) begin
        acc[ch_ptr] <= acc[ch_ptr] + fword[ch_ptr];
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cfg_rdy       <= 1'b0;
      ch_ptr        <= '0;
      s1_valid      <= 1'b0;
      s1_ch         <= '0;
      s1_addr       <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else begin
      cfg_rdy <= 1'b1;
      if (en) begin
        ch_ptr        <= (ch_ptr == LAST) ? '0 : ch_ptr + 1'b1;
        s1_valid      <= 1'b1;
        s1_ch         <= ch_ptr;
        s1_addr       <= ph_sum[PHASE_W-1 -: LUT_AW];
        m_axis.tvalid <= s1_valid;
        m_axis.tuser  <= s1_ch;
        m_axis.tlast  <= s1_valid & (s1_ch == LAST);
      end
    end
  end

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .aclk   (aclk),
    .arst_n (arst_n),
    .en     (en),
    .addr   (s1_addr),
    .data   (lut_q)
  );

  assign m_axis.tdata = lut_q;

endmodule

// File: tb/tb_nco_mc.sv
// tb_nco_mc: randomized self-checking bench for nco_mc against an
// event-indexed per-channel phase model and an ideal sine reference.
module tb_nco_mc;

  localparam int NCH = 5;
  localparam int PW  = 32;
  localparam int AW  = 10;
  localparam int OW  = 16;
  localparam int CW  = 3;

  logic aclk = 1'b0;
  logic arst_n = 1'b0;
  logic sync_clr = 1'b0;
  logic dither_en = 1'b0;
  logic [NCH*PW-1:0] poff;

  nco_mc_if #(.DW(PW), .UW(CW)) cfg_if ();
  nco_mc_if #(.DW(OW), .UW(CW)) m_if ();

  nco_mc #(
    .NUM_CH  (NCH),
    .PHASE_W (PW),
    .LUT_AW  (AW),
    .OUT_W   (OW)
  ) dut (
    .aclk         (aclk),
    .arst_n       (arst_n),
    .s_axis_cfg   (cfg_if),
    .phase_offset (poff),
    .sync_clr     (sync_clr),
    .dither_en    (dither_en),
    .m_axis       (m_if)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          t;
    bit          clr;
    int          ch;
    logic [31:0] v;
  } ev_t;

  int checks = 0;
  int errors = 0;

  // Model: event t applies to issues with index >= t.
  ev_t         evq[$];
  logic [31:0] m_acc [NCH];
  logic [31:0] m_fw  [NCH];
  logic [31:0] off   [NCH];
  int          ev_e;
  int          out_idx;
  int          ch0_hist[$];
  int          last_ch0;
  bit          pair_chk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_val(input logic [31:0] ph);
    int  a;
    real r;
    a = int'(ph[31:22]);
    r = 32767.0 * $sin(2.0 * 3.14159265358979
                       * (real'(a) + 0.5) / 1024.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  task automatic reset_model();
    evq.delete();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = '0;
      m_fw[i]  = '0;
    end
    ev_e    = 0;
    out_idx = 0;
  endtask

  // Sample pre-edge state, score any accepted beat, log events, advance.
  task automatic tick();
    bit          en_now;
    int          c;
    int          sd;
    logic [31:0] ph;
    ev_t         ev;
    #1;
    en_now = !m_if.tvalid || m_if.tready;
    if (m_if.tvalid && m_if.tready) begin
      while (evq.size() > 0 && evq[0].t <= out_idx) begin
        ev = evq.pop_front();
        if (ev.clr) begin
          for (int i = 0; i < NCH; i++) m_acc[i] = '0;
        end else begin
          m_fw[ev.ch] = ev.v;
        end
      end
      c  = out_idx % NCH;
      ph = m_acc[c] + off[c];
      m_acc[c] = m_acc[c] + m_fw[c];
      sd = int'($signed(m_if.tdata));
      chk("tuser", 32'(m_if.tuser), c);
      chk("tlast", 32'(m_if.tlast), 32'(c == NCH - 1));
      chk("sample", sd, ref_val(ph));
      if (c == 0) begin
        ch0_hist.push_back(sd);
        last_ch0 = sd;
      end
      if (c == 1 && pair_chk) chk("antiphase", sd, -last_ch0);
      out_idx++;
    end
    if (cfg_if.tvalid && cfg_if.tready
        && int'(cfg_if.tuser) < NCH) begin
      evq.push_back('{t: en_now ? ev_e + 1 : ev_e, clr: 1'b0,
                      ch: int'(cfg_if.tuser), v: cfg_if.tdata});
    end
    if (sync_clr) begin
      evq.push_back('{t: en_now ? ev_e + 1 : ev_e, clr: 1'b1,
                      ch: 0, v: '0});
    end
    if (en_now) ev_e++;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    logic signed [31:0] hd;
    logic [31:0]        hu;
    logic [31:0]        hl;
    int                 h0;

    off[0] = 32'h0;
    off[1] = 32'h8000_0000;
    for (int i = 2; i < NCH; i++) off[i] = $urandom;
    for (int i = 0; i < NCH; i++) poff[i*PW +: PW] = off[i];
    cfg_if.tvalid = 1'b0;
    cfg_if.tdata  = '0;
    cfg_if.tuser  = '0;
    cfg_if.tlast  = 1'b0;
    m_if.tready   = 1'b1;
    pair_chk      = 1'b0;
    last_ch0      = 0;
    reset_model();

    #12;
    chk("rst_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_tdata", 32'(m_if.tdata), 0);
    chk("rst_tuser", 32'(m_if.tuser), 0);
    chk("rst_tlast", 32'(m_if.tlast), 0);
    chk("rst_cfg_rdy", 32'(cfg_if.tready), 0);

    @(negedge aclk);
    arst_n = 1'b1;
    tick();
    chk("cfg_rdy", 32'(cfg_if.tready), 1);

    cfg_if.tvalid = 1'b1;
    cfg_if.tuser  = 3'd0;
    cfg_if.tdata  = 32'h0040_0000;
    tick();
    cfg_if.tuser  = 3'd1;
    tick();
    cfg_if.tuser  = 3'd5;
    cfg_if.tdata  = 32'hDEAD_BEEF;
    tick();
    cfg_if.tvalid = 1'b0;
    pair_chk = 1'b1;

    // Random throttling and background writes to ch2..4 / invalid ids.
    for (int i = 0; i < 20000 && ch0_hist.size() < 1030; i++) begin
      m_if.tready   = ($urandom_range(0, 3) != 0);
      cfg_if.tvalid = ($urandom_range(0, 7) == 0);
      cfg_if.tuser  = CW'($urandom_range(2, 7));
      cfg_if.tdata  = $urandom;
      tick();
    end
    cfg_if.tvalid = 1'b0;
    chk("ch0_beats", 32'(ch0_hist.size() >= 1030), 1);
    if (ch0_hist.size() >= 1030) begin
      chk("first", ch0_hist[0], 101);
      chk("a0", ch0_hist[1], 101);
      chk("a255", ch0_hist[256], 32767);
      chk("a512", ch0_hist[513], -101);
      chk("period1", ch0_hist[1025], ch0_hist[1]);
      chk("period2", ch0_hist[1029], ch0_hist[5]);
    end

    // Stall with a cfg write in the middle.
    m_if.tready = 1'b1;
    tick();
    tick();
    m_if.tready = 1'b0;
    hd = 32'($signed(m_if.tdata));
    hu = 32'(m_if.tuser);
    hl = 32'(m_if.tlast);
    chk("stall_valid", 32'(m_if.tvalid), 1);
    for (int i = 0; i < 10; i++) begin
      cfg_if.tvalid = (i == 4);
      cfg_if.tuser  = 3'd3;
      cfg_if.tdata  = $urandom;
      tick();
      chk("stall_data", 32'($signed(m_if.tdata)), hd);
      chk("stall_user", 32'(m_if.tuser), hu);
      chk("stall_last", 32'(m_if.tlast), hl);
    end
    cfg_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Synchronous clear mid-stream, then an out-of-range write.
    pair_chk = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    h0 = ch0_hist.size();
    cfg_if.tvalid = 1'b1;
    cfg_if.tuser  = 3'd6;
    cfg_if.tdata  = $urandom;
    tick();
    cfg_if.tvalid = 1'b0;
    for (int i = 0; i < 2 * NCH + 2; i++) tick();
    chk("clr_beats", 32'(ch0_hist.size() >= h0 + 2), 1);
    if (ch0_hist.size() >= h0 + 2) begin
      chk("clr_restart",
          32'(ch0_hist[h0] == 101 || ch0_hist[h0+1] == 101), 1);
    end
    for (int i = 0; i < 300; i++) begin
      m_if.tready = ($urandom_range(0, 1) != 0);
      tick();
    end

    // Asynchronous reset while a beat is presented.
    m_if.tready = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(m_if.tvalid), 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_tvalid", 32'(m_if.tvalid), 0);
    chk("async_cfg_rdy", 32'(cfg_if.tready), 0);
    reset_model();
    @(negedge aclk);
    arst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 32'(m_if.tvalid), 1);
    chk("post_rst_tuser", 32'(m_if.tuser), 0);
    for (int i = 0; i < 30; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
